// File: rtl/mux_rd_arbiter.sv
// mux_rd_arbiter: round-robin arbiter that shares one registered-select
// combinational mux read port between R requesters. A two-stage pipeline
// (S1 = select register, S2 = response register) returns read data in
// acceptance order with full-rate pass-through and clean backpressure.
module mux_rd_arbiter #(
  parameter int N  = 4,
  parameter int AW = 10,
  parameter int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [R-1:0]  req_valid_i,
  input  logic [AW-1:0] req_addr_i [0:R-1],
  output logic [R-1:0]  req_ready_o,
  output logic [AW-1:0] sel_o,
  input  logic [N-1:0]  mux_data_i,
  output logic          rsp_valid_o,
  output logic [IW-1:0] rsp_id_o,
  output logic [N-1:0]  rsp_data_o,
  input  logic          rsp_ready_i
);

  // S1 stage: the select register doubles as the read address of the mux
  logic [AW-1:0] sel_q, sel_d;
  logic          s1Valid_q, s1Valid_d;
  logic [IW-1:0] s1Id_q, s1Id_d;
  logic [IW-1:0] rrPtr_q, rrPtr_d;

  // S2 stage: registered response
  logic          rspValid_q, rspValid_d;
  logic [IW-1:0] rspId_q, rspId_d;
  logic [N-1:0]  rspData_q, rspData_d;

  logic          adv2;
  logic          acc1;
  logic          grantFound;
  logic [IW-1:0] grantIdx;

  // Modulo-R increment of a requester index; R need not be a power of two
  function automatic logic [IW-1:0] rrIndex(input logic [IW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= R) sum = sum - R;
    return IW'(sum);
  endfunction

  assign adv2 = !rspValid_q || rsp_ready_i;
  assign acc1 = !s1Valid_q || adv2;

  // Round-robin search: first valid requester at or after the pointer wins
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < R; k++) begin
      if (!grantFound && req_valid_i[rrIndex(rrPtr_q, k)]) begin
        grantFound = 1'b1;
        grantIdx   = rrIndex(rrPtr_q, k);
      end
    end
  end

  // Ready is one-hot on the winner only, and only when S1 can take it
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < R; i++) begin
      req_ready_o[i] = !rst_i && acc1 && grantFound && (grantIdx == IW'(i));
    end
  end

  // S1 next state: load on acceptance, empty on an idle accept slot, hold on stall
  always_comb begin
    sel_d     = sel_q;
    s1Id_d    = s1Id_q;
    s1Valid_d = s1Valid_q;
    rrPtr_d   = rrPtr_q;
    if (acc1) begin
      if (grantFound) begin
        sel_d     = req_addr_i[grantIdx];
        s1Id_d    = grantIdx;
        s1Valid_d = 1'b1;
        rrPtr_d   = rrIndex(grantIdx, 1);
      end else begin
        s1Valid_d = 1'b0;
      end
    end
  end

  // S2 next state: capture mux data for a valid S1 entry when the consumer allows
  always_comb begin
    rspValid_d = rspValid_q;
    rspId_d    = rspId_q;
    rspData_d  = rspData_q;
    if (adv2) begin
      rspValid_d = s1Valid_q;
      if (s1Valid_q) begin
        rspId_d   = s1Id_q;
        rspData_d = mux_data_i;
      end
    end
  end

  // Pipeline registers with synchronous reset discarding in-flight work
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q      <= '0;
      s1Id_q     <= '0;
      s1Valid_q  <= 1'b0;
      rrPtr_q    <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspData_q  <= '0;
    end else begin
      sel_q      <= sel_d;
      s1Id_q     <= s1Id_d;
      s1Valid_q  <= s1Valid_d;
      rrPtr_q    <= rrPtr_d;
      rspValid_q <= rspValid_d;
      rspId_q    <= rspId_d;
      rspData_q  <= rspData_d;
    end
  end

  assign sel_o       = sel_q;
  assign rsp_valid_o = rspValid_q;
  assign rsp_id_o    = rspId_q;
  assign rsp_data_o  = rspData_q;

endmodule

// File: tb/tb_mux_rd_arbiter.sv
// Testbench for mux_rd_arbiter: directed scenarios plus a long random run.
// A slot-based reference model predicts ready/select/response every cycle;
// a scoreboard queue carries accepted requests to an independent monitor.
module tb_mux_rd_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int R  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [R-1:0]  reqValid = '0;
  logic [AW-1:0] reqAddr [0:R-1];
  logic [R-1:0]  reqReady;
  logic [AW-1:0] sel;
  logic [N-1:0]  muxData;
  logic          rspValid;
  logic [IW-1:0] rspId;
  logic [N-1:0]  rspData;
  logic          rspReady = 1'b1;

  mux_rd_arbiter #(.N(N), .AW(AW), .R(R)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(reqValid),
    .req_addr_i(reqAddr),
    .req_ready_o(reqReady),
    .sel_o(sel),
    .mux_data_i(muxData),
    .rsp_valid_o(rspValid),
    .rsp_id_o(rspId),
    .rsp_data_o(rspData),
    .rsp_ready_i(rspReady)
  );

  always #5 clk = ~clk;

  // External mux: data is the low nibble of the selected address
  assign muxData = sel[N-1:0];

  typedef struct {
    bit valid;
    int id;
    int addr;
  } slot_t;

  typedef struct {
    int id;
    int data;
  } exp_t;

  slot_t       s1M;
  slot_t       s2M;
  int          rrM;
  exp_t        sbQ[$];
  int          dutGrantLog[$];
  int          rspIdLog[$];
  int          rspDataLog[$];
  int          total = 0;
  int          bad = 0;
  int          acceptCount = 0;
  int          dutAccepts = 0;
  logic [R-1:0] hsVec = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts outputs, then advances by the arbitration rules
  always @(negedge clk) begin : refModel
    int w;
    int idx;
    bit found;
    bit acc1;
    bit adv2;
    logic [R-1:0] expRdy;
    if (rst) begin
      checkOutput("ready_in_reset", 32'(reqReady), 0);
      s1M = '{valid: 1'b0, id: 0, addr: 0};
      s2M = '{valid: 1'b0, id: 0, addr: 0};
      rrM = 0;
      sbQ.delete();
      hsVec = '0;
    end else begin
      checkOutput("rsp_valid", 32'(rspValid), 32'(s2M.valid));
      checkOutput("rsp_id", 32'(rspId), s2M.id);
      checkOutput("rsp_data", 32'(rspData), s2M.addr % 16);
      checkOutput("sel", 32'(sel), s1M.addr);
      found = 1'b0;
      w = 0;
      for (int k = 0; k < R; k++) begin
        idx = (rrM + k) % R;
        if (!found && reqValid[idx]) begin
          found = 1'b1;
          w = idx;
        end
      end
      adv2 = !s2M.valid || rspReady;
      acc1 = !s1M.valid || adv2;
      expRdy = '0;
      if (acc1 && found) expRdy[w] = 1'b1;
      checkOutput("req_ready", 32'(reqReady), 32'(expRdy));
      checkOutput("ready_onehot0", 32'($onehot0(reqReady)), 1);
      hsVec = reqValid & reqReady;
      for (int i = 0; i < R; i++) begin
        if (hsVec[i]) begin
          dutGrantLog.push_back(i);
          dutAccepts++;
        end
      end
      if (adv2) begin
        if (s1M.valid) s2M = s1M;
        else s2M.valid = 1'b0;
      end
      if (acc1) begin
        if (found) begin
          s1M = '{valid: 1'b1, id: w, addr: int'(reqAddr[w])};
          rrM = (w + 1) % R;
          sbQ.push_back('{id: w, data: int'(reqAddr[w]) % 16});
          acceptCount++;
        end else begin
          s1M.valid = 1'b0;
        end
      end
    end
  end

  // Monitor: every consumed response must match the oldest accepted request
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rspValid && rspReady) begin
      checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("sb_id", 32'(rspId), e.id);
        checkOutput("sb_data", 32'(rspData), e.data);
        rspIdLog.push_back(int'(rspId));
        rspDataLog.push_back(int'(rspData));
      end
    end
  end

  // One cycle of requester/consumer behaviour; pRdy < 0 leaves rspReady alone
  task automatic applyStimulus(input int pNew, input int pRdy);
    @(posedge clk);
    #1;
    for (int i = 0; i < R; i++) begin
      if (hsVec[i]) reqValid[i] = 1'b0;
    end
    for (int i = 0; i < R; i++) begin
      if (!reqValid[i] && ($urandom_range(99) < pNew)) begin
        reqValid[i] = 1'b1;
        reqAddr[i]  = AW'($urandom);
      end
    end
    if (pRdy >= 0) rspReady = ($urandom_range(99) < pRdy);
  endtask

  task automatic raise(input int i, input int addr);
    reqValid[i] = 1'b1;
    reqAddr[i]  = AW'(addr);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    reqValid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int startAcc;
    int cycles;
    for (int i = 0; i < R; i++) reqAddr[i] = '0;

    // Reset and reset-state outputs
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    raise(2, 'h3A5);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rspValid), 0);
    checkOutput("reset_sel", 32'(sel), 0);
    checkOutput("reset_rsp_data", 32'(rspData), 0);

    // Single read from requester 2
    checkOutput("single_ready", 32'(reqReady), 32'h4);
    applyStimulus(0, 100);
    @(negedge clk);
    checkOutput("single_sel", 32'(sel), 32'h3A5);
    applyStimulus(0, 100);
    @(negedge clk);
    checkOutput("single_rsp_valid", 32'(rspValid), 1);
    checkOutput("single_rsp_id", 32'(rspId), 2);
    checkOutput("single_rsp_data", 32'(rspData), 5);
    repeat (3) applyStimulus(0, 100);

    // Fairness with all requesters continuously valid
    doReset();
    rspReady = 1'b1;
    dutGrantLog.delete();
    for (int i = 0; i < R; i++) raise(i, int'($urandom_range(1023)));
    repeat (6) applyStimulus(100, 100);
    checkOutput("fair_count", 32'(dutGrantLog.size()), 6);
    if (dutGrantLog.size() >= 6) begin
      for (int i = 0; i < 6; i++) checkOutput("fair_order", 32'(dutGrantLog[i]), 32'(i % R));
    end
    repeat (4) applyStimulus(0, 100);

    // Backpressure: consumer stalled for five cycles
    doReset();
    rspReady = 1'b0;
    startAcc = dutAccepts;
    raise(0, int'($urandom_range(1023)));
    raise(1, int'($urandom_range(1023)));
    repeat (5) applyStimulus(0, 0);
    checkOutput("bp_accepts", 32'(dutAccepts - startAcc), 2);
    rspIdLog.delete();
    rspReady = 1'b1;
    repeat (4) applyStimulus(0, 100);
    checkOutput("bp_rsp_count", 32'(rspIdLog.size()), 2);
    if (rspIdLog.size() == 2) begin
      checkOutput("bp_first_id", 32'(rspIdLog[0]), 0);
      checkOutput("bp_second_id", 32'(rspIdLog[1]), 1);
    end

    // Pointer wrap with boundary addresses
    doReset();
    rspReady = 1'b1;
    raise(2, int'($urandom_range(1023)));
    applyStimulus(0, 100);
    raise(3, 'h3FF);
    raise(0, 'h000);
    dutGrantLog.delete();
    rspIdLog.delete();
    rspDataLog.delete();
    repeat (4) applyStimulus(0, 100);
    checkOutput("wrap_grants", 32'(dutGrantLog.size()), 2);
    if (dutGrantLog.size() == 2) begin
      checkOutput("wrap_grant0", 32'(dutGrantLog[0]), 3);
      checkOutput("wrap_grant1", 32'(dutGrantLog[1]), 0);
    end
    checkOutput("wrap_rsp_count", 32'(rspIdLog.size() >= 2), 1);
    if (rspIdLog.size() >= 2) begin
      checkOutput("wrap_id_a", 32'(rspIdLog[rspIdLog.size()-2]), 3);
      checkOutput("wrap_data_a", 32'(rspDataLog[rspDataLog.size()-2]), 32'hF);
      checkOutput("wrap_id_b", 32'(rspIdLog[rspIdLog.size()-1]), 0);
      checkOutput("wrap_data_b", 32'(rspDataLog[rspDataLog.size()-1]), 0);
    end

    // Reset pulse with both pipeline stages occupied
    rspReady = 1'b0;
    raise(1, int'($urandom_range(1023)));
    raise(2, int'($urandom_range(1023)));
    repeat (3) applyStimulus(0, 0);
    checkOutput("midrst_s2_full", 32'(rspValid), 1);
    rst = 1'b1;
    rspReady = 1'b1;
    for (int i = 0; i < R; i++) begin
      if (!reqValid[i]) raise(i, int'($urandom_range(1023)));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rspValid), 0);
    checkOutput("midrst_first_grant", 32'(reqReady), 32'h1);
    repeat (8) applyStimulus(0, 100);

    // Random traffic: 10k accepted requests, random consumer readiness
    startAcc = acceptCount;
    cycles = 0;
    while ((acceptCount - startAcc) < 10000 && cycles < 60000) begin
      applyStimulus(50, 70);
      cycles++;
    end
    checkOutput("random_no_timeout", 32'(cycles < 60000), 1);

    // Drain remaining work
    cycles = 0;
    while ((reqValid != '0 || sbQ.size() != 0) && cycles < 200) begin
      applyStimulus(0, 100);
      cycles++;
    end
    checkOutput("drain_sb_empty", 32'(sbQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
